// File: rtl/rect_fall_sched.sv
// rect_fall_sched: gravity scheduler for up to N_OBJ falling rectangles.
// One shared prescaler ticks a sequencer that walks all objects per tick.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         spawn request pulse
//   lift          lift request for the most recently spawned object
//   clear         level: LANDED objects return to IDLE with ypos 0
//   pause         level: prescaler count held, no ticks
//   ypos_bus      object i ypos at [i*YW +: YW]
//   active        object i falling
//   landed        object i resting on the floor
//   landed_pulse  1-cycle pulse when a scan lands an object
//   spawn_fail    1-cycle pulse when a spawn finds no IDLE object
//   tick_overrun  sticky: tick arrived while one was still pending
//   busy          sequencer not waiting
module rect_fall_sched #(
  parameter int N_OBJ      = 4,
  parameter int TICK_DIV   = 4_000_000,
  parameter int VER_PIXELS = 600,
  parameter int YW         = 12,
  parameter int FALL_STEP  = 1,
  parameter int LIFT_STEP  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              lift,
  input  logic              clear,
  input  logic              pause,
  output logic [N_OBJ*YW-1:0] ypos_bus,
  output logic [N_OBJ-1:0]  active,
  output logic [N_OBJ-1:0]  landed,
  output logic              landed_pulse,
  output logic              spawn_fail,
  output logic              tick_overrun,
  output logic              busy
);

  localparam int IW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [YW:0]   FLOOR_W = (YW+1)'(VER_PIXELS-1);
  localparam logic [YW:0]   STEP_W  = (YW+1)'(FALL_STEP);
  localparam logic [YW-1:0] FLOOR_Y = YW'(VER_PIXELS-1);
  localparam logic [YW-1:0] LIFT_Y  = YW'(LIFT_STEP);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV-1);
  localparam logic [IW-1:0] IDX_MAX = IW'(N_OBJ-1);

  typedef enum logic [1:0] {
    S_WAIT, S_SCAN, S_SPAWN, S_LIFT
  } seq_t;

  typedef enum logic [1:0] {
    O_IDLE, O_FALL, O_LANDED
  } obj_t;

  seq_t            r_seq, w_seq_nx;
  logic [CW-1:0]   r_cnt;
  logic            w_tick_req;
  logic            r_tick_p, r_start_p, r_lift_p;
  logic            w_tick_clr, w_start_clr, w_lift_clr;
  logic            r_ovr, r_lpulse, r_sfail;
  logic [IW-1:0]   r_idx, r_last;
  logic            r_last_v;
  obj_t            r_st [N_OBJ];
  logic [YW-1:0]   r_y  [N_OBJ];

  logic [YW-1:0]   w_sy, w_ly, w_lift_y;
  logic [YW:0]     w_sum;
  logic            w_land;
  logic            w_free_v;
  logic [IW-1:0]   w_free_i;

  assign w_tick_req = !pause && (r_cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!pause) begin
      r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seq <= S_WAIT;
    end else begin
      r_seq <= w_seq_nx;
    end
  end

  always_comb begin
    w_seq_nx    = r_seq;
    w_tick_clr  = 1'b0;
    w_start_clr = 1'b0;
    w_lift_clr  = 1'b0;
    unique case (r_seq)
      S_WAIT: begin
        if (r_tick_p) begin
          w_seq_nx   = S_SCAN;
          w_tick_clr = 1'b1;
        end else if (r_start_p) begin
          w_seq_nx    = S_SPAWN;
          w_start_clr = 1'b1;
        end else if (r_lift_p) begin
          w_seq_nx   = S_LIFT;
          w_lift_clr = 1'b1;
        end
      end
      S_SCAN: begin
        if (r_idx == IDX_MAX) w_seq_nx = S_WAIT;
      end
      S_SPAWN: w_seq_nx = S_WAIT;
      S_LIFT:  w_seq_nx = S_WAIT;
      default: w_seq_nx = S_WAIT;
    endcase
  end

  // A request arriving on its own service edge stays pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_p  <= 1'b0;
      r_start_p <= 1'b0;
      r_lift_p  <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_tick_p  <= w_tick_req | (r_tick_p & ~w_tick_clr);
      r_start_p <= start | (r_start_p & ~w_start_clr);
      r_lift_p  <= lift | (r_lift_p & ~w_lift_clr);
      r_ovr     <= r_ovr | (w_tick_req & r_tick_p);
    end
  end

  assign w_sy   = r_y[r_idx];
  assign w_sum  = {1'b0, w_sy} + STEP_W;
  assign w_land = (w_sum >= FLOOR_W);

  assign w_ly     = r_y[r_last];
  assign w_lift_y = (w_ly >= LIFT_Y) ? w_ly - LIFT_Y : '0;

  always_comb begin
    w_free_v = 1'b0;
    w_free_i = '0;
    for (int i = N_OBJ-1; i >= 0; i--) begin
      if (r_st[i] == O_IDLE) begin
        w_free_v = 1'b1;
        w_free_i = IW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_OBJ; i++) begin
        r_st[i] <= O_IDLE;
        r_y[i]  <= '0;
      end
      r_idx    <= '0;
      r_last   <= '0;
      r_last_v <= 1'b0;
      r_lpulse <= 1'b0;
      r_sfail  <= 1'b0;
    end else begin
      r_lpulse <= 1'b0;
      r_sfail  <= 1'b0;
      r_idx    <= (r_seq == S_SCAN) ? r_idx + IW'(1) : '0;
      unique case (r_seq)
        S_SCAN: begin
          if (r_st[r_idx] == O_FALL) begin
            if (w_land) begin
              r_y[r_idx]  <= FLOOR_Y;
              r_st[r_idx] <= O_LANDED;
              r_lpulse    <= 1'b1;
            end else begin
              r_y[r_idx] <= w_sum[YW-1:0];
            end
          end
        end
        S_SPAWN: begin
          if (w_free_v) begin
            r_st[w_free_i] <= O_FALL;
            r_y[w_free_i]  <= '0;
            r_last         <= w_free_i;
            r_last_v       <= 1'b1;
          end else begin
            r_sfail <= 1'b1;
          end
        end
        S_LIFT: begin
          if (r_last_v && r_st[r_last] == O_FALL) begin
            r_y[r_last] <= w_lift_y;
          end
        end
        default: ;
      endcase
      // Clear only touches LANDED objects; a fresh spawn keeps last_valid.
      if (clear) begin
        for (int i = 0; i < N_OBJ; i++) begin
          if (r_st[i] == O_LANDED) begin
            r_st[i] <= O_IDLE;
            r_y[i]  <= '0;
            if (r_last_v && r_last == IW'(i) &&
                !(r_seq == S_SPAWN && w_free_v)) begin
              r_last_v <= 1'b0;
            end
          end
        end
      end
    end
  end

  always_comb begin
    ypos_bus = '0;
    active   = '0;
    landed   = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      ypos_bus[i*YW +: YW] = r_y[i];
      active[i] = (r_st[i] == O_FALL);
      landed[i] = (r_st[i] == O_LANDED);
    end
  end

  assign landed_pulse = r_lpulse;
  assign spawn_fail   = r_sfail;
  assign tick_overrun = r_ovr;
  assign busy         = (r_seq != S_WAIT);

endmodule

// File: tb/tb_rect_fall_sched.sv
// tb_rect_fall_sched: directed bench for rect_fall_sched.
// Spawn outcomes go through an expectation queue.
module tb_rect_fall_sched;

  localparam int N  = 4;
  localparam int YW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, lift, clear, pause;
  logic [N*YW-1:0] ypos_bus;
  logic [N-1:0] active, landed;
  logic landed_pulse, spawn_fail, tick_overrun, busy;

  logic start_b, lift_b, pause_b;
  logic [N*YW-1:0] ypos_bus_b;
  logic [N-1:0] active_b, landed_b;
  logic landed_pulse_b, spawn_fail_b, tick_overrun_b, busy_b;

  rect_fall_sched #(
    .N_OBJ(N), .TICK_DIV(8), .VER_PIXELS(8),
    .YW(YW), .FALL_STEP(1), .LIFT_STEP(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .lift(lift),
    .clear(clear), .pause(pause), .ypos_bus(ypos_bus),
    .active(active), .landed(landed),
    .landed_pulse(landed_pulse), .spawn_fail(spawn_fail),
    .tick_overrun(tick_overrun), .busy(busy)
  );

  // Divider well below the scan length: ticks pile up.
  rect_fall_sched #(
    .N_OBJ(N), .TICK_DIV(3), .VER_PIXELS(8),
    .YW(YW), .FALL_STEP(1), .LIFT_STEP(3)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .lift(lift_b),
    .clear(1'b0), .pause(pause_b), .ypos_bus(ypos_bus_b),
    .active(active_b), .landed(landed_b),
    .landed_pulse(landed_pulse_b), .spawn_fail(spawn_fail_b),
    .tick_overrun(tick_overrun_b), .busy(busy_b)
  );

  int n_chk = 0;
  int n_err = 0;
  int exp_q[$];

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic longint yp(input int i);
    return longint'(ypos_bus[i*YW +: YW]);
  endfunction

  task automatic do_start(input string tag, input int exp_idx,
                          input int exp_lat);
    logic [N-1:0] prev, nw;
    int lat, got, e;
    bit seen;
    exp_q.push_back(exp_idx);
    prev = active;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    lat = 0;
    seen = 1'b0;
    got = -2;
    for (int t = 0; t < 20 && !seen; t++) begin
      cyc(1);
      lat++;
      nw = active & ~prev;
      if (nw != '0) begin
        seen = 1'b1;
        for (int i = N-1; i >= 0; i--) if (nw[i]) got = i;
      end else if (spawn_fail) begin
        seen = 1'b1;
        got = -1;
      end
    end
    chk({tag, "_seen"}, longint'(seen), 1);
    e = exp_q.pop_front();
    chk({tag, "_idx"}, longint'(got), longint'(e));
    chk({tag, "_lat"}, longint'(lat), longint'(exp_lat));
  endtask

  task automatic tick1(input string tag, output int lp);
    int t;
    lp = 0;
    pause = 1'b0;
    t = 0;
    while (!busy && t < 40) begin
      cyc(1);
      t++;
    end
    chk({tag, "_scan_start"}, longint'(busy), 1);
    pause = 1'b1;
    t = 0;
    while (busy && t < 20) begin
      cyc(1);
      t++;
      if (landed_pulse) lp++;
    end
    chk({tag, "_scan_end"}, longint'(busy), 0);
  endtask

  task automatic do_lift();
    lift = 1'b1;
    cyc(1);
    lift = 1'b0;
    cyc(3);
  endtask

  initial begin
    int lp, lps, bcnt, lat, got, e;
    bit seen;
    rst = 1'b1; start = 1'b0; lift = 1'b0;
    clear = 1'b0; pause = 1'b1;
    start_b = 1'b0; lift_b = 1'b0; pause_b = 1'b1;
    cyc(3);
    chk("rst_ypos", longint'(ypos_bus), 0);
    chk("rst_active", longint'(active), 0);
    chk("rst_landed", longint'(landed), 0);
    chk("rst_flags", longint'({landed_pulse, spawn_fail,
                               tick_overrun, busy}), 0);
    chk("rst_b_ovr", longint'({tick_overrun_b, busy_b}), 0);
    rst = 1'b0;

    do_start("spawn_a", 0, 2);
    chk("spawn_a_active", longint'(active), 1);
    chk("spawn_a_y0", yp(0), 0);
    tick1("t1", lp);
    chk("t1_y0", yp(0), 1);
    tick1("t2", lp);
    chk("t2_y0", yp(0), 2);
    do_lift();
    chk("lift_sat_y0", yp(0), 0);
    for (int k = 0; k < 5; k++) tick1("t3", lp);
    chk("t3_y0", yp(0), 5);
    do_lift();
    chk("lift_sub_y0", yp(0), 2);
    for (int k = 0; k < 4; k++) tick1("t4", lp);
    chk("t4_y0", yp(0), 6);
    chk("t4_landed", longint'(landed), 0);
    tick1("land", lp);
    chk("land_y0", yp(0), 7);
    chk("land_landed", longint'(landed), 1);
    chk("land_active", longint'(active), 0);
    chk("land_pulse_cnt", longint'(lp), 1);
    lps = 0;
    for (int k = 0; k < 2; k++) begin
      tick1("floor", lp);
      lps += lp;
    end
    chk("floor_y0", yp(0), 7);
    chk("floor_pulse_cnt", longint'(lps), 0);
    do_lift();
    chk("lift_landed_y0", yp(0), 7);

    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("clr_landed", longint'(landed), 0);
    chk("clr_ypos", longint'(ypos_bus), 0);

    for (int k = 0; k < N; k++) do_start("spawn_n", k, 2);
    chk("full_active", longint'(active), 15);
    do_start("spawn_fail", -1, 2);
    chk("fail_active", longint'(active), 15);
    chk("fail_ypos", longint'(ypos_bus), 0);

    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    pause = 1'b0;
    cyc(7);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    exp_q.push_back(0);
    bcnt = 0; lat = 0; seen = 1'b0; got = -2;
    for (int t = 0; t < 20 && !seen; t++) begin
      cyc(1);
      lat++;
      if (lat <= 5 && busy) bcnt++;
      if (active != '0) begin
        seen = 1'b1;
        for (int i = N-1; i >= 0; i--) if (active[i]) got = i;
      end
    end
    pause = 1'b1;
    chk("race_seen", longint'(seen), 1);
    e = exp_q.pop_front();
    chk("race_idx", longint'(got), longint'(e));
    chk("race_lat", longint'(lat), N + 3);
    chk("race_busy_cnt", longint'(bcnt), N);

    bcnt = 0;
    for (int t = 0; t < 20; t++) begin
      cyc(1);
      if (busy) bcnt++;
    end
    chk("pause_busy_cnt", longint'(bcnt), 0);
    chk("pause_y0", yp(0), 0);
    chk("pause_active", longint'(active), 1);
    tick1("resume", lp);
    chk("resume_y0", yp(0), 1);

    pause = 1'b0;
    for (int t = 0; t < 40 && !busy; t++) cyc(1);
    chk("mid_scan_busy", longint'(busy), 1);
    pause = 1'b1;
    cyc(2);
    rst = 1'b1;
    #1;
    chk("mid_rst_ypos", longint'(ypos_bus), 0);
    chk("mid_rst_state", longint'({active, landed}), 0);
    cyc(1);
    chk("mid_rst_flags", longint'({landed_pulse, spawn_fail,
                                   tick_overrun, busy}), 0);
    chk("mid_rst_ypos2", longint'(ypos_bus), 0);
    rst = 1'b0;

    pause_b = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      start_b = (t % 2 == 0);
      lift_b  = (t % 2 == 1);
      cyc(1);
      if (tick_overrun_b) seen = 1'b1;
    end
    start_b = 1'b0;
    lift_b = 1'b0;
    pause_b = 1'b1;
    chk("ovr_set", longint'(seen), 1);
    cyc(10);
    chk("ovr_sticky", longint'(tick_overrun_b), 1);
    chk("ovr_main_clean", longint'(tick_overrun), 0);
    rst = 1'b1;
    cyc(1);
    chk("ovr_rst", longint'(tick_overrun_b), 0);
    rst = 1'b0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
